// File: rtl/hxd32_pkg.sv
// Shared arbiter types: ownership FSM encoding and master count.
package hxd32_pkg;

  localparam int ARB_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_burst_cnt.sv
// Burst beat counter: counts accepted beats of the current owner, saturating at MAX_BURST.
// limit_o flags that a beat accepted now is (at least) the MAX_BURST-th of the tenure.
module arb_burst_cnt #(
  parameter int MAX_BURST = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  localparam int CW = $clog2(MAX_BURST + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < CW'(MAX_BURST))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = (cnt_q >= CW'(MAX_BURST - 1));

endmodule

// File: rtl/ram_arbiter.sv
// Two-master single-port RAM arbiter with registered grants; reads return one cycle after the beat.
// HXD32_ARB_RR_EN: round-robin IDLE ties and burst limit on both masters; otherwise m0 has priority.
module ram_arbiter
  import hxd32_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MAX_BURST = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            m0_req_i,
  input  logic            m0_wr_en_i,
  input  logic [XLEN-1:0] m0_addr_i,
  input  logic [XLEN-1:0] m0_wr_data_i,
  input  logic [3:0]      m0_wr_byte_en_i,
  output logic            m0_gnt_o,
  output logic            m0_rd_valid_o,
  input  logic            m1_req_i,
  input  logic            m1_wr_en_i,
  input  logic [XLEN-1:0] m1_addr_i,
  input  logic [XLEN-1:0] m1_wr_data_i,
  input  logic [3:0]      m1_wr_byte_en_i,
  output logic            m1_gnt_o,
  output logic            m1_rd_valid_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            ram_en_o,
  output logic [XLEN-1:0] ram_addr_o,
  output logic [XLEN-1:0] ram_wr_data_o,
  output logic [3:0]      ram_wr_byte_en_o,
  input  logic [XLEN-1:0] ram_rd_data_i
);

  localparam int OW = $clog2(ARB_MASTERS);

`ifdef HXD32_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_t    state_q, state_d;
  logic [OW-1:0] last_owner_q;
  logic          rd_vld0_q, rd_vld1_q;
  logic          acc0, acc1;
  logic          burst_limit;
  logic          cnt_clr;
  arb_state_t    tie_rr, tie_state;

  assign acc0 = m0_req_i && (state_q == OWN0);
  assign acc1 = m1_req_i && (state_q == OWN1);

  assign tie_rr    = (last_owner_q == OW'(1)) ? OWN0 : OWN1;
  assign tie_state = RR_EN ? tie_rr : OWN0;

  // Without round-robin m0 keeps the bus for as long as it keeps requesting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req_i && m1_req_i) state_d = tie_state;
        else if (m0_req_i)        state_d = OWN0;
        else if (m1_req_i)        state_d = OWN1;
      end
      OWN0: begin
        if (!m0_req_i)                              state_d = m1_req_i ? OWN1 : IDLE;
        else if (RR_EN && m1_req_i && burst_limit) state_d = OWN1;
      end
      OWN1: begin
        if (!m1_req_i)                     state_d = m0_req_i ? OWN0 : IDLE;
        else if (m0_req_i && burst_limit) state_d = OWN0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cnt_clr = (state_q == IDLE) || (state_d != state_q);

  arb_burst_cnt #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (cnt_clr),
    .inc_i  (acc0 || acc1),
    .limit_o(burst_limit)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      last_owner_q <= OW'(1);
      rd_vld0_q    <= 1'b0;
      rd_vld1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld0_q <= acc0 && !m0_wr_en_i;
      rd_vld1_q <= acc1 && !m1_wr_en_i;
      if (state_d == OWN0 && state_q != OWN0) last_owner_q <= OW'(0);
      if (state_d == OWN1 && state_q != OWN1) last_owner_q <= OW'(1);
    end
  end

  always_comb begin
    ram_en_o         = 1'b0;
    ram_addr_o       = '0;
    ram_wr_data_o    = '0;
    ram_wr_byte_en_o = 4'b0000;
    if (acc0) begin
      ram_en_o         = 1'b1;
      ram_addr_o       = m0_addr_i;
      ram_wr_data_o    = m0_wr_data_i;
      ram_wr_byte_en_o = m0_wr_en_i ? m0_wr_byte_en_i : 4'b0000;
    end else if (acc1) begin
      ram_en_o         = 1'b1;
      ram_addr_o       = m1_addr_i;
      ram_wr_data_o    = m1_wr_data_i;
      ram_wr_byte_en_o = m1_wr_en_i ? m1_wr_byte_en_i : 4'b0000;
    end
  end

  assign m0_gnt_o      = (state_q == OWN0);
  assign m1_gnt_o      = (state_q == OWN1);
  assign m0_rd_valid_o = rd_vld0_q;
  assign m1_rd_valid_o = rd_vld1_q;
  assign rd_data_o     = ram_rd_data_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter (MAX_BURST=4); read returns tracked by a tagged scoreboard.
module tb_ram_arbiter;

  localparam int XLEN = 32;
  localparam int MB   = 4;
`ifdef HXD32_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m0_req, m0_wr, m1_req, m1_wr;
  logic [XLEN-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]      m0_be, m1_be;
  logic            m0_gnt, m1_gnt, m0_rv, m1_rv;
  logic [XLEN-1:0] rd_data, ram_addr, ram_wdata;
  logic            ram_en;
  logic [3:0]      ram_be;
  logic [XLEN-1:0] ram_rd_data = '0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN:0] sb_q[$];

  ram_arbiter #(.XLEN(XLEN), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_wr_en_i(m0_wr), .m0_addr_i(m0_addr),
    .m0_wr_data_i(m0_wdata), .m0_wr_byte_en_i(m0_be),
    .m0_gnt_o(m0_gnt), .m0_rd_valid_o(m0_rv),
    .m1_req_i(m1_req), .m1_wr_en_i(m1_wr), .m1_addr_i(m1_addr),
    .m1_wr_data_i(m1_wdata), .m1_wr_byte_en_i(m1_be),
    .m1_gnt_o(m1_gnt), .m1_rd_valid_o(m1_rv),
    .rd_data_o(rd_data), .ram_en_o(ram_en), .ram_addr_o(ram_addr),
    .ram_wr_data_o(ram_wdata), .ram_wr_byte_en_o(ram_be),
    .ram_rd_data_i(ram_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN-1:0] ram_fn(input logic [XLEN-1:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  // RAM model: read data appears one cycle after the strobe
  always @(posedge clk) ram_rd_data <= ram_fn(ram_addr);

  always @(negedge clk) begin : sb_check
    logic [XLEN:0] exp_e;
    if (rst_n && (m0_rv || m1_rv)) begin
      n_checks++;
      if (m0_rv && m1_rv) begin
        n_fail++; $display("FAIL sb_both_valid: rv0=%0b rv1=%0b, required one-hot", m0_rv, m1_rv);
      end else if (sb_q.size() == 0) begin
        n_fail++; $display("FAIL sb_unexpected_valid: rv0=%0b rv1=%0b data=%h, required no valid", m0_rv, m1_rv, rd_data);
      end else begin
        exp_e = sb_q.pop_front();
        if ({m1_rv, rd_data} !== exp_e)
          begin n_fail++; $display("FAIL sb_read: got m%0d data=%h, required m%0d data=%h", m1_rv, rd_data, exp_e[XLEN], exp_e[XLEN-1:0]); end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic drv0(input logic r, input logic w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d, input logic [3:0] b);
    m0_req = r; m0_wr = w; m0_addr = a; m0_wdata = d; m0_be = b;
  endtask

  task automatic drv1(input logic r, input logic w, input logic [XLEN-1:0] a, input logic [XLEN-1:0] d, input logic [3:0] b);
    m1_req = r; m1_wr = w; m1_addr = a; m1_wdata = d; m1_be = b;
  endtask

  task automatic sb_push(input logic m, input logic [XLEN-1:0] a);
    sb_q.push_back({m, ram_fn(a)});
  endtask

  task automatic apply_reset();
    drv0(0, 0, '0, '0, '0); drv1(0, 0, '0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv0(0, 0, '0, '0, '0); drv1(0, 0, '0, '0, '0);
    #3;
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b, required 00", {m0_gnt, m1_gnt}); end
    n_checks++; if ({m0_rv, m1_rv} !== 2'b00) begin n_fail++; $display("FAIL rst_rv: got %b, required 00", {m0_rv, m1_rv}); end
    n_checks++; if ({ram_en, ram_be} !== 5'b0) begin n_fail++; $display("FAIL rst_ram_en_be: got %b, required 0", {ram_en, ram_be}); end
    n_checks++; if ({ram_addr, ram_wdata} !== '0) begin n_fail++; $display("FAIL rst_addr_data: got %h/%h, required 0", ram_addr, ram_wdata); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    tick(); drv0(1, 0, 32'h100, '0, '0);
    @(negedge clk);
    n_checks++; if ({m0_gnt, ram_en} !== 2'b00) begin n_fail++; $display("FAIL sr_c0: gnt0/en=%b, required 00", {m0_gnt, ram_en}); end
    tick(); sb_push(0, 32'h100);
    @(negedge clk);
    n_checks++; if ({m0_gnt, m1_gnt, ram_en} !== 3'b101) begin n_fail++; $display("FAIL sr_c1_gnt: got %b, required 101", {m0_gnt, m1_gnt, ram_en}); end
    n_checks++; if (ram_addr !== 32'h100 || ram_be !== 4'b0) begin n_fail++; $display("FAIL sr_c1_addr: addr=%h be=%b, required 100/0000", ram_addr, ram_be); end
    tick(); drv0(0, 0, '0, '0, '0);
    @(negedge clk);
    n_checks++; if (m0_rv !== 1'b1 || rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sr_c2_rv: rv0=%b data=%h, required 1/deadbeef", m0_rv, rd_data); end
    tick(); @(negedge clk);
    n_checks++; if ({m0_gnt, m0_rv, ram_en} !== 3'b000) begin n_fail++; $display("FAIL sr_c3_idle: got %b, required 000", {m0_gnt, m0_rv, ram_en}); end
  endtask

  task automatic test_contention();
    int eo;
    logic [XLEN-1:0] ea;
    apply_reset();
    for (int c = 0; c < 18; c++) begin
      tick();
      drv0(1, 0, 32'h1000 + 32'(c * 4), '0, '0);
      drv1(1, 0, 32'h3000 + 32'(c * 4), '0, '0);
      eo = (c == 0) ? -1 : (RR ? (((c - 1) / MB) % 2) : 0);
      ea = (eo == 1) ? m1_addr : ((eo == 0) ? m0_addr : '0);
      if (eo == 0) sb_push(0, m0_addr);
      if (eo == 1) sb_push(1, m1_addr);
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt, ram_en} !== {eo == 0, eo == 1, eo >= 0} || ram_addr !== ea) begin
        n_fail++; $display("FAIL cont_c%0d: gnt0/gnt1/en=%b addr=%h, required %b addr=%h", c, {m0_gnt, m1_gnt, ram_en}, ram_addr, {eo == 0, eo == 1, eo >= 0}, ea);
      end
    end
    tick(); drv0(0, 0, '0, '0, '0); drv1(0, 0, '0, '0, '0);
    tick(); @(negedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL cont_drain: %0d reads pending, required 0", sb_q.size()); end
  endtask

  task automatic test_write_handoff();
    int be_hits = 0;
    tick(); drv1(1, 1, 32'h2000, 32'hCAFEF00D, 4'b0011);
    @(negedge clk);
    if (ram_be == 4'b0011) be_hits++;
    n_checks++; if ({m0_gnt, m1_gnt, ram_en} !== 3'b000) begin n_fail++; $display("FAIL wh_c0: got %b, required 000", {m0_gnt, m1_gnt, ram_en}); end
    tick(); drv0(1, 0, 32'h40, '0, '0);
    @(negedge clk);
    if (ram_be == 4'b0011) be_hits++;
    n_checks++; if ({m0_gnt, m1_gnt, ram_en} !== 3'b011) begin n_fail++; $display("FAIL wh_c1_gnt: got %b, required 011", {m0_gnt, m1_gnt, ram_en}); end
    n_checks++;
    if (ram_addr !== 32'h2000 || ram_wdata !== 32'hCAFEF00D || ram_be !== 4'b0011) begin
      n_fail++; $display("FAIL wh_c1_wr: addr=%h data=%h be=%b, required 2000/cafef00d/0011", ram_addr, ram_wdata, ram_be);
    end
    tick(); drv1(0, 0, '0, '0, '0);
    @(negedge clk);
    if (ram_be == 4'b0011) be_hits++;
    n_checks++; if ({m0_gnt, m1_gnt, ram_en, ram_be} !== 7'b0100000) begin n_fail++; $display("FAIL wh_c2: got %b, required 0100000", {m0_gnt, m1_gnt, ram_en, ram_be}); end
    tick(); sb_push(0, 32'h40);
    @(negedge clk);
    if (ram_be == 4'b0011) be_hits++;
    n_checks++; if ({m0_gnt, m1_gnt, ram_en} !== 3'b101 || ram_addr !== 32'h40) begin n_fail++; $display("FAIL wh_c3_gnt0: got %b addr=%h, required 101 addr=40", {m0_gnt, m1_gnt, ram_en}, ram_addr); end
    tick(); drv0(0, 0, '0, '0, '0);
    @(negedge clk);
    n_checks++; if (be_hits != 1) begin n_fail++; $display("FAIL wh_be_once: byte_en 0011 seen %0d times, required 1", be_hits); end
    tick(); @(negedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL wh_drain: %0d reads pending, required 0", sb_q.size()); end
  endtask

  task automatic test_burst_end_read();
    int eo;
    apply_reset();
    tick(); drv1(1, 0, 32'h3100, '0, '0);
    @(negedge clk);
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL be_c0: got %b, required 00", {m0_gnt, m1_gnt}); end
    for (int c = 1; c < 7; c++) begin
      tick();
      drv1(1, 0, 32'h3100 + 32'(c * 4), '0, '0);
      drv0(1, 0, 32'h0700 + 32'(c * 4), '0, '0);
      eo = (c <= MB) ? 1 : 0;
      if (eo == 0) sb_push(0, m0_addr); else sb_push(1, m1_addr);
      @(negedge clk);
      n_checks++; if ({m0_gnt, m1_gnt} !== {eo == 0, eo == 1}) begin n_fail++; $display("FAIL be_c%0d_gnt: got %b, required %b", c, {m0_gnt, m1_gnt}, {eo == 0, eo == 1}); end
      if (c == MB + 1) begin
        n_checks++; if ({m0_rv, m1_rv} !== 2'b01) begin n_fail++; $display("FAIL be_switch_rv: rv0/rv1=%b, required 01", {m0_rv, m1_rv}); end
      end
    end
    tick(); drv0(0, 0, '0, '0, '0); drv1(0, 0, '0, '0, '0);
    tick(); @(negedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL be_drain: %0d reads pending, required 0", sb_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    tick(); drv0(1, 0, 32'h500, '0, '0);
    tick(); sb_push(0, 32'h500);
    @(negedge clk);
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_gnt0: got %b, required 1", m0_gnt); end
    tick(); drv0(1, 0, 32'h504, '0, '0); drv1(1, 1, 32'h2400, 32'h12345678, 4'b1111);
    #1 rst_n = 1'b0;
    #1 sb_q.delete();
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_rv, m1_rv, ram_en, ram_be} !== 9'b0 || {ram_addr, ram_wdata} !== '0) begin
      n_fail++; $display("FAIL rm_async: ctl=%b addr=%h data=%h, required all 0", {m0_gnt, m1_gnt, m0_rv, m1_rv, ram_en, ram_be}, ram_addr, ram_wdata);
    end
    tick(); @(negedge clk);
    n_checks++; if ({m0_gnt, m1_gnt, m0_rv, ram_en} !== 4'b0) begin n_fail++; $display("FAIL rm_held: got %b, required 0000", {m0_gnt, m1_gnt, m0_rv, ram_en}); end
    #1 rst_n = 1'b1;
    #1;
    n_checks++; if ({m0_gnt, m1_gnt, ram_en, ram_be} !== 7'b0) begin n_fail++; $display("FAIL rm_release: got %b, required 0", {m0_gnt, m1_gnt, ram_en, ram_be}); end
    tick(); sb_push(0, 32'h504);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, ram_en, ram_be} !== 7'b1010000 || ram_addr !== 32'h504) begin
      n_fail++; $display("FAIL rm_tie_m0: got %b addr=%h, required 1010000 addr=504", {m0_gnt, m1_gnt, ram_en, ram_be}, ram_addr);
    end
    tick(); drv0(0, 0, '0, '0, '0); drv1(0, 0, '0, '0, '0);
    tick(); @(negedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL rm_drain: %0d reads pending, required 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_handoff();
    test_burst_end_read();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
